// File: rtl/phase_scheduler.sv
// phase_scheduler: right-of-way controller for a four-approach intersection.
// Picks one approach at a time, with preferential override and per-approach
// forced red, and walks it through green, yellow and all-red clearance.
// Also provides a flashing-yellow attention mode.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   attention      request flashing-yellow mode
//   requests[3:0]  per-approach vehicle demand
//   preferentials  per-approach priority-vehicle demand
//   force_reds     per-approach inhibit (held red, never granted)
//   ltfs[3:0]      lamps per approach, index 0 red / 1 yellow / 2 green
//   grant[3:0]     one-hot approach currently green or yellow, else 0
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_CLEAR  | all red; arbitrate once clearance time has elapsed
// S_GREEN  | granted approach green; timer counts green cycles
// S_YELLOW | granted approach yellow for a fixed time
// S_ATTN   | flashing yellow on non-inhibited approaches, no grant

module phase_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int CLEAR_T   = 2,
  parameter int BLINK_T   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             attention,
  input  logic [3:0]       requests,
  input  logic [3:0]       preferentials,
  input  logic [3:0]       force_reds,
  output logic [3:0][0:2]  ltfs,
  output logic [3:0]       grant
);

  localparam int M1 = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int M2 = (M1 > CLEAR_T) ? M1 : CLEAR_T;
  localparam int M3 = (M2 > 2 * BLINK_T) ? M2 : 2 * BLINK_T;
  localparam int TW = $clog2(M3 + 1);

  localparam logic [TW-1:0] GMIN_LAST = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_LAST = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] CLR_LAST  = TW'(CLEAR_T - 1);
  localparam logic [TW-1:0] BLINK_ON  = TW'(BLINK_T);
  localparam logic [TW-1:0] ATTN_LAST = TW'(2 * BLINK_T - 1);

  localparam logic [2:0] L_RED  = 3'b100;
  localparam logic [2:0] L_YEL  = 3'b010;
  localparam logic [2:0] L_GRN  = 3'b001;
  localparam logic [2:0] L_DARK = 3'b000;

  typedef enum logic [1:0] {S_CLEAR, S_GREEN, S_YELLOW, S_ATTN} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      g_q, g_d;
  logic [3:0][0:2] ltfs_q, ltfs_d;
  logic [3:0]      grant_q, grant_d;

  logic [3:0] eligible, pref_elig, onehot_g;
  logic [1:0] winner, idx;
  logic       found, end_green;

  // Arbitration: preferential lowest index first, else round-robin from rr_ptr.
  always_comb begin
    eligible  = (requests | preferentials) & ~force_reds;
    pref_elig = preferentials & ~force_reds;
    winner    = rr_ptr_q;
    found     = 1'b0;
    idx       = 2'd0;
    if (pref_elig != 4'd0) begin
      for (int i = 3; i >= 0; i--) begin
        if (pref_elig[i]) winner = 2'(i);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        idx = rr_ptr_q + 2'(k);
        if (!found && eligible[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    onehot_g  = 4'b0001 << g_q;
    end_green = force_reds[g_q]
             || ((timer_q >= GMIN_LAST) && !(requests[g_q] || preferentials[g_q]))
             || ((timer_q >= GMIN_LAST) && ((pref_elig & ~onehot_g) != 4'd0))
             || ((timer_q == GMAX_LAST) && ((eligible & ~onehot_g) != 4'd0));
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rr_ptr_d = rr_ptr_q;
    g_d      = g_q;

    if (attention && state_q != S_ATTN) begin
      state_d = S_ATTN;
      timer_d = '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (timer_q >= CLR_LAST) begin
            // Timer stays saturated so arbitration is retried every cycle.
            timer_d = CLR_LAST;
            if (eligible != 4'd0) begin
              state_d  = S_GREEN;
              timer_d  = '0;
              g_d      = winner;
              rr_ptr_d = winner + 2'd1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_GREEN: begin
          if (end_green) begin
            state_d = S_YELLOW;
            timer_d = '0;
          end else if (timer_q != GMAX_LAST) begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_YELLOW: begin
          if (timer_q >= YEL_LAST) begin
            state_d = S_CLEAR;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_ATTN: begin
          if (!attention) begin
            state_d = S_CLEAR;
            timer_d = '0;
          end else if (timer_q >= ATTN_LAST) begin
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = S_CLEAR;
          timer_d = '0;
        end
      endcase
    end
  end

  // Lamps are decoded from the next state so each pattern appears on the
  // edge that enters its state.
  always_comb begin
    ltfs_d  = {4{L_RED}};
    grant_d = 4'd0;
    case (state_d)
      S_GREEN: begin
        ltfs_d[g_d] = L_GRN;
        grant_d     = 4'b0001 << g_d;
      end
      S_YELLOW: begin
        ltfs_d[g_d] = L_YEL;
        grant_d     = 4'b0001 << g_d;
      end
      S_ATTN: begin
        for (int i = 0; i < 4; i++) begin
          if (!force_reds[i]) ltfs_d[i] = (timer_d < BLINK_ON) ? L_YEL : L_DARK;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      timer_q  <= '0;
      rr_ptr_q <= 2'd0;
      g_q      <= 2'd0;
      ltfs_q   <= {4{L_RED}};
      grant_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      rr_ptr_q <= rr_ptr_d;
      g_q      <= g_d;
      ltfs_q   <= ltfs_d;
      grant_q  <= grant_d;
    end
  end

  assign ltfs  = ltfs_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler. Inputs change and outputs are sampled
// on the falling edge; expected lamp patterns are written as {a3,a2,a1,a0}.
module tb_phase_scheduler;

  logic            clk = 1'b0;
  logic            rst;
  logic            attention;
  logic [3:0]      requests;
  logic [3:0]      preferentials;
  logic [3:0]      force_reds;
  logic [3:0][0:2] ltfs;
  logic [3:0]      grant;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] D = 3'b000;

  always #5 clk = ~clk;

  phase_scheduler dut (
    .clk(clk),
    .rst(rst),
    .attention(attention),
    .requests(requests),
    .preferentials(preferentials),
    .force_reds(force_reds),
    .ltfs(ltfs),
    .grant(grant)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [11:0] el, input logic [3:0] eg);
    n_assert++;
    assert (ltfs === el && grant === eg)
    else begin
      n_fail++;
      $error("FAIL %s: ltfs=%h grant=%b, expected ltfs=%h grant=%b", tag, ltfs, grant, el, eg);
    end
  endtask

  task automatic run_chk(input int n, input string tag, input logic [11:0] el,
                         input logic [3:0] eg);
    repeat (n) begin
      chk(tag, el, eg);
      tick();
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    attention     = 1'b0;
    requests      = 4'd0;
    preferentials = 4'd0;
    force_reds    = 4'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset, single request: two clear cycles, then rest in green.
    do_reset();
    requests = 4'b0001;
    run_chk(2, "s1_clear", {R, R, R, R}, 4'b0000);
    run_chk(12, "s1_rest", {R, R, R, G}, 4'b0001);

    // Competing requests 0 and 2: green runs to the max before handing over.
    requests = 4'b0101;
    chk("s2_g0_last", {R, R, R, G}, 4'b0001);
    tick();
    run_chk(2, "s2_y0", {R, R, R, Y}, 4'b0001);
    run_chk(2, "s2_c0", {R, R, R, R}, 4'b0000);
    run_chk(8, "s2_g2", {R, G, R, R}, 4'b0100);
    run_chk(2, "s2_y2", {R, Y, R, R}, 4'b0100);
    run_chk(2, "s2_c2", {R, R, R, R}, 4'b0000);
    run_chk(8, "s2_g0b", {R, R, R, G}, 4'b0001);
    run_chk(2, "s2_y0b", {R, R, R, Y}, 4'b0001);
    run_chk(2, "s2_c0b", {R, R, R, R}, 4'b0000);
    run_chk(1, "s2_g2b", {R, G, R, R}, 4'b0100);

    // Preferential on approach 3 arrives while approach 1 is at timer 1.
    do_reset();
    requests = 4'b0010;
    run_chk(2, "s3_clear", {R, R, R, R}, 4'b0000);
    run_chk(1, "s3_g1_t0", {R, R, G, R}, 4'b0010);
    preferentials = 4'b1000;
    requests      = 4'b0110;
    run_chk(3, "s3_g1", {R, R, G, R}, 4'b0010);
    run_chk(2, "s3_y1", {R, R, Y, R}, 4'b0010);
    run_chk(2, "s3_c1", {R, R, R, R}, 4'b0000);
    run_chk(2, "s3_g3", {G, R, R, R}, 4'b1000);

    // Forced red cuts green short, yellow still full, approach then inhibited.
    do_reset();
    requests = 4'b0001;
    run_chk(2, "s4_clear", {R, R, R, R}, 4'b0000);
    run_chk(1, "s4_g0_t0", {R, R, R, G}, 4'b0001);
    chk("s4_g0_t1", {R, R, R, G}, 4'b0001);
    force_reds = 4'b0001;
    tick();
    run_chk(2, "s4_y0", {R, R, R, Y}, 4'b0001);
    run_chk(8, "s4_hold", {R, R, R, R}, 4'b0000);
    force_reds = 4'b0000;
    chk("s4_release", {R, R, R, R}, 4'b0000);
    tick();
    chk("s4_regrant", {R, R, R, G}, 4'b0001);

    // Attention mode from green of approach 2, approach 1 inhibited.
    do_reset();
    requests = 4'b0100;
    run_chk(2, "s5_clear", {R, R, R, R}, 4'b0000);
    run_chk(1, "s5_g2", {R, G, R, R}, 4'b0100);
    chk("s5_g2_t1", {R, G, R, R}, 4'b0100);
    attention  = 1'b1;
    force_reds = 4'b0010;
    tick();
    run_chk(2, "s5_on", {Y, Y, R, Y}, 4'b0000);
    run_chk(2, "s5_off", {D, D, R, D}, 4'b0000);
    run_chk(2, "s5_on2", {Y, Y, R, Y}, 4'b0000);
    run_chk(2, "s5_off2", {D, D, R, D}, 4'b0000);
    chk("s5_on3", {Y, Y, R, Y}, 4'b0000);
    attention  = 1'b0;
    force_reds = 4'b0000;
    tick();
    run_chk(2, "s5_exit", {R, R, R, R}, 4'b0000);
    chk("s5_resume", {R, G, R, R}, 4'b0100);

    // Reset in the middle of approach 3 yellow.
    do_reset();
    requests = 4'b1000;
    run_chk(2, "s6_clear", {R, R, R, R}, 4'b0000);
    requests = 4'b0000;
    run_chk(4, "s6_g3", {G, R, R, R}, 4'b1000);
    chk("s6_y3", {Y, R, R, R}, 4'b1000);
    rst = 1'b1;
    tick();
    chk("s6_rst", {R, R, R, R}, 4'b0000);
    rst      = 1'b0;
    requests = 4'b1001;
    tick();
    chk("s6_clear2", {R, R, R, R}, 4'b0000);
    tick();
    chk("s6_first", {R, R, R, G}, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
